batch_dispatcher: RTL and testbench
===================================

Name: batch_dispatcher

Overview:
- Parametrised successor to the fixed 256×16-bit, 32-bit-bus receive/execute/send controller in the Xillybus top level.
- Reads BUS_WIDTH-bit words from the host-to-FPGA FIFO and unpacks them into THREAD_NUMBER lanes of LANE_WIDTH bits for the kernel array.
- Waits until every kernel output is valid, or until a programmable timeout expires, then packs the results and writes them to the FPGA-to-host FIFO.
- Adds the following over the previous controller: full-vector completion detect, exec timeout, send backpressure on every word, abort on channel close, and batch/timeout status.

Parameters:
- BUS_WIDTH, 32, FIFO word width in bits; must be an integer multiple of LANE_WIDTH.
- LANE_WIDTH, 16, per-thread data width in bits.
- THREAD_NUMBER, 256, number of kernel threads; must be a multiple of LANES = BUS_WIDTH/LANE_WIDTH.
- EXEC_TIMEOUT, 4096, maximum EXEC cycles; 0 disables the timeout.

Ports:
- bus_clk  in  1  single clock for the block.
- bus_rst_n  in  1  asynchronous active-low reset.
- enable  in  1  high while both host channels are open and quiesce is low.
- recv_empty  in  1  host-to-FPGA FIFO empty.
- recv_rden  out  1  host-to-FPGA FIFO read enable.
- recv_data  in  BUS_WIDTH  FIFO data; valid the cycle recv_valid is high.
- recv_valid  in  1  FIFO data valid; one cycle after an accepted rden.
- in_data  out  THREAD_NUMBER*LANE_WIDTH  flattened kernel inputs; thread t occupies [t*LANE_WIDTH +: LANE_WIDTH].
- in_valid  out  THREAD_NUMBER  per-thread input valid (level).
- out_data  in  THREAD_NUMBER*LANE_WIDTH  flattened kernel outputs, same packing as in_data.
- out_valid  in  THREAD_NUMBER  per-thread output valid.
- send_full  in  1  FPGA-to-host FIFO full.
- send_wren  out  1  FPGA-to-host FIFO write enable.
- send_data  out  BUS_WIDTH  packed result word.
- busy  out  1  state != IDLE.
- timeout_flag  out  1  sticky; set when an EXEC ends by timeout.
- batch_count  out  32  completed batches, wraps modulo 2^32.

Behaviour:
- Derived constant: WORDS = THREAD_NUMBER/LANES.
- Reset values: state=IDLE, all counters 0, in_data=0, in_valid=0, send_wren=0, recv_rden=0, timeout_flag=0, batch_count=0.
- Abort: enable low in any state → IDLE on the next edge.
  - In-flight recv_valid data is discarded.
  - in_valid is cleared in IDLE.
  - timeout_flag is cleared while enable is low.
- IDLE:
  - in_valid=0, counters cleared.
  - enable high → RECV.
- RECV, read issue:
  - recv_rden = (state==RECV) && !recv_empty && (issue_cnt < WORDS); issue_cnt increments on each asserted rden.
  - Never more than WORDS reads are issued per batch.
- RECV, data capture:
  - On recv_valid, word w = word_cnt is written to lanes w*LANES .. w*LANES+LANES-1.
  - Lane 0 is taken from the least-significant LANE_WIDTH bits.
  - The matching in_valid bits are set on the same edge, and word_cnt increments.
  - recv_valid with word_cnt==WORDS-1 → EXEC.
- EXEC:
  - exec_timer increments each cycle.
  - Exit when &out_valid → SEND.
  - Otherwise exit when EXEC_TIMEOUT != 0 and exec_timer == EXEC_TIMEOUT-1 → SEND, and set timeout_flag.
  - If both conditions hold in the same cycle, completion wins and timeout_flag is not set.
- SEND:
  - send_wren = (state==SEND) && !send_full.
  - send_data is the combinational pack of out_data lanes send_idx*LANES.. (lowest lane in the LSBs).
  - send_idx increments only when the write is accepted; send_full stalls without skipping or duplicating a word.
  - Accepted write with send_idx==WORDS-1 → IDLE and batch_count+1.
- Back-to-back batches: IDLE lasts one cycle when enable stays high. Minimum batch cycles = 1 + (WORDS+1) + exec + WORDS.
- in_valid is held through EXEC and SEND and drops in IDLE, which restarts the kernels.
- Counter widths are $clog2(WORDS+1) and $clog2(EXEC_TIMEOUT+1); no arithmetic overflow within one batch.

Test Plan:
Configuration: THREAD_NUMBER=8, BUS_WIDTH=32, LANE_WIDTH=16, EXEC_TIMEOUT=20 (WORDS=4).
- Nominal batch:
  - Stimulus: push 0x00020001, 0x00040003, 0x00060005, 0x00080007; kernels echo input+1 with all out_valid high 3 cycles after EXEC entry.
  - Required: in_valid goes 0x03→0x0F→0x3F→0xFF; send_data = 0x00030002, 0x00050004, 0x00070006, 0x00090008; batch_count=1; busy falls.
- Starved receive: recv_empty toggles every other cycle → exactly 4 rden pulses and a correct lane mapping.
- Send backpressure: send_full high for 5 cycles after the first accepted word → no send_wren during the stall; 4 total accepted words in order; no duplicate of word 1.
- Timeout: out_valid=0x7F permanently → SEND exactly 20 cycles after EXEC entry; timeout_flag=1 and stays 1 over the next batch until enable drops.
- Abort: enable drops after 2 words are received → IDLE on the next edge, in_valid=0; after re-enable, a fresh batch of 4 words maps to lanes 0-7 with no residue.
- Reset: bus_rst_n asserted mid-SEND, async with no clock edge → send_wren=0, busy=0, batch_count=0 immediately.

Source files
------------

// File: rtl/batch_dispatcher.sv
// Batch dispatcher: unpacks host FIFO words into kernel lanes, waits for the
// kernels (or a timeout), then packs the results back to the host FIFO.

module batch_dispatcher_lane #(
    parameter int W = 16
) (
    input  logic         bus_clk,
    input  logic         bus_rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         vld
);
    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            dout <= '0;
            vld  <= 1'b0;
        end else if (clr) begin
            vld  <= 1'b0;
        end else if (load) begin
            dout <= din;
            vld  <= 1'b1;
        end
    end
endmodule

module batch_dispatcher #(
    parameter int BUS_WIDTH     = 32,
    parameter int LANE_WIDTH    = 16,
    parameter int THREAD_NUMBER = 256,
    parameter int EXEC_TIMEOUT  = 4096
) (
    input  logic                                bus_clk,
    input  logic                                bus_rst_n,
    input  logic                                enable,
    input  logic                                recv_empty,
    output logic                                recv_rden,
    input  logic [BUS_WIDTH-1:0]                recv_data,
    input  logic                                recv_valid,
    output logic [THREAD_NUMBER*LANE_WIDTH-1:0] in_data,
    output logic [THREAD_NUMBER-1:0]            in_valid,
    input  logic [THREAD_NUMBER*LANE_WIDTH-1:0] out_data,
    input  logic [THREAD_NUMBER-1:0]            out_valid,
    input  logic                                send_full,
    output logic                                send_wren,
    output logic [BUS_WIDTH-1:0]                send_data,
    output logic                                busy,
    output logic                                timeout_flag,
    output logic [31:0]                         batch_count
);
    localparam int LANES = BUS_WIDTH / LANE_WIDTH;
    localparam int WORDS = THREAD_NUMBER / LANES;
    localparam int CW    = $clog2(WORDS + 1);
    localparam int TW    = (EXEC_TIMEOUT > 0) ? $clog2(EXEC_TIMEOUT + 1) : 1;
    localparam int SW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {IDLE, RECV, EXEC, SEND} state_t;

    state_t          state, state_d;
    logic [CW-1:0]   issue_cnt, word_cnt, send_idx;
    logic [TW-1:0]   exec_timer;
    logic            cap, tmo, send_acc, batch_done;

    // Result word w is exactly lanes w*LANES.. in the flattened vector.
    logic [WORDS-1:0][BUS_WIDTH-1:0] out_words;
    assign out_words = out_data;
    assign send_data = out_words[send_idx[SW-1:0]];
    assign busy      = (state != IDLE);

    always_comb begin
        state_d    = state;
        recv_rden  = 1'b0;
        send_wren  = 1'b0;
        cap        = 1'b0;
        tmo        = 1'b0;
        send_acc   = 1'b0;
        batch_done = 1'b0;
        case (state)
            IDLE: if (enable) state_d = RECV;
            RECV: begin
                recv_rden = !recv_empty && (issue_cnt < CW'(WORDS));
                cap       = recv_valid;
                if (recv_valid && word_cnt == CW'(WORDS - 1)) state_d = EXEC;
            end
            EXEC: begin
                if (&out_valid) begin
                    state_d = SEND;
                end else if (EXEC_TIMEOUT != 0 && exec_timer == TW'(EXEC_TIMEOUT - 1)) begin
                    state_d = SEND;
                    tmo     = 1'b1;
                end
            end
            SEND: begin
                send_wren = !send_full;
                send_acc  = send_wren;
                if (send_acc && send_idx == CW'(WORDS - 1)) begin
                    state_d    = IDLE;
                    batch_done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Channel close aborts the batch; late recv data is dropped.
        if (!enable) begin
            state_d    = IDLE;
            cap        = 1'b0;
            tmo        = 1'b0;
            batch_done = 1'b0;
        end
    end

    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            state        <= IDLE;
            issue_cnt    <= '0;
            word_cnt     <= '0;
            send_idx     <= '0;
            exec_timer   <= '0;
            timeout_flag <= 1'b0;
            batch_count  <= '0;
        end else begin
            state <= state_d;
            if (state_d == IDLE) begin
                issue_cnt  <= '0;
                word_cnt   <= '0;
                send_idx   <= '0;
                exec_timer <= '0;
            end else begin
                if (recv_rden) issue_cnt <= issue_cnt + 1'b1;
                if (cap)       word_cnt  <= word_cnt + 1'b1;
                if (state == EXEC && EXEC_TIMEOUT != 0) exec_timer <= exec_timer + 1'b1;
                if (send_acc)  send_idx  <= send_idx + 1'b1;
            end
            if (!enable)  timeout_flag <= 1'b0;
            else if (tmo) timeout_flag <= 1'b1;
            if (batch_done) batch_count <= batch_count + 32'd1;
        end
    end

    // Thread t takes lane t%LANES of word t/LANES; valid drops on IDLE entry.
    for (genvar t = 0; t < THREAD_NUMBER; t++) begin : g_lane
        localparam int W_IDX = t / LANES;
        localparam int L_IDX = t % LANES;
        batch_dispatcher_lane #(.W(LANE_WIDTH)) u_lane (
            .bus_clk   (bus_clk),
            .bus_rst_n (bus_rst_n),
            .clr       (state_d == IDLE),
            .load      (cap && (word_cnt == CW'(W_IDX))),
            .din       (recv_data[L_IDX*LANE_WIDTH +: LANE_WIDTH]),
            .dout      (in_data[t*LANE_WIDTH +: LANE_WIDTH]),
            .vld       (in_valid[t])
        );
    end
endmodule

// File: tb/tb_batch_dispatcher.sv
// Directed/randomized bench for batch_dispatcher with a host FIFO, echo
// kernel and result sink modelled at transaction level.

module tb_batch_dispatcher;
    localparam int BW = 32, LW = 16, TN = 8, TO = 20;

    logic           bus_clk = 1'b0;
    logic           bus_rst_n;
    logic           enable;
    logic           recv_empty = 1'b1;
    logic           recv_rden;
    logic [BW-1:0]  recv_data = '0;
    logic           recv_valid = 1'b0;
    logic [TN*LW-1:0] in_data;
    logic [TN-1:0]  in_valid;
    logic [TN*LW-1:0] out_data;
    logic [TN-1:0]  out_valid;
    logic           send_full;
    logic           send_wren;
    logic [BW-1:0]  send_data;
    logic           busy;
    logic           timeout_flag;
    logic [31:0]    batch_count;

    batch_dispatcher #(.BUS_WIDTH(BW), .LANE_WIDTH(LW), .THREAD_NUMBER(TN), .EXEC_TIMEOUT(TO)) dut (
        .bus_clk(bus_clk), .bus_rst_n(bus_rst_n), .enable(enable),
        .recv_empty(recv_empty), .recv_rden(recv_rden), .recv_data(recv_data),
        .recv_valid(recv_valid), .in_data(in_data), .in_valid(in_valid),
        .out_data(out_data), .out_valid(out_valid), .send_full(send_full),
        .send_wren(send_wren), .send_data(send_data), .busy(busy),
        .timeout_flag(timeout_flag), .batch_count(batch_count)
    );

    always #5 bus_clk = ~bus_clk;

    int checks = 0, errors = 0;
    logic [BW-1:0] q[$];
    logic [BW-1:0] got[$];
    logic [TN-1:0] ivq[$];
    logic [TN-1:0] last_iv = '0;
    int  rden_cnt = 0, wren_full = 0, kcnt = 0, kdelay = 3, exp_batches = 0;
    bit  starve = 0, tgl = 0, tmo_mode = 0;

    // Host-to-FPGA FIFO: data appears one cycle after an accepted read.
    always @(posedge bus_clk) begin
        if (recv_rden && !recv_empty && q.size() > 0) begin
            recv_data  <= q.pop_front();
            recv_valid <= 1'b1;
        end else begin
            recv_valid <= 1'b0;
        end
    end
    always @(negedge bus_clk) begin
        #1;
        tgl = !tgl;
        recv_empty = (q.size() == 0) || (starve && tgl);
    end

    // Echo kernel: output = input + 1, all valid kdelay cycles after full input.
    always @(posedge bus_clk) kcnt <= (&in_valid) ? kcnt + 1 : 0;
    always_comb begin
        out_data = '0;
        for (int t = 0; t < TN; t++) out_data[t*LW +: LW] = in_data[t*LW +: LW] + 16'd1;
    end
    assign out_valid = tmo_mode ? 8'h7F : ((kcnt >= kdelay) ? 8'hFF : 8'h00);

    always @(posedge bus_clk) begin
        if (send_wren && !send_full) got.push_back(send_data);
        if (send_wren && send_full)  wren_full++;
        if (recv_rden)               rden_cnt++;
    end
    always @(negedge bus_clk) begin
        if (in_valid !== last_iv) begin
            ivq.push_back(in_valid);
            last_iv = in_valid;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BW-1:0] echo_word(input logic [BW-1:0] w);
        logic [15:0] lo, hi;
        lo = w[15:0] + 16'd1;
        hi = w[31:16] + 16'd1;
        return {hi, lo};
    endfunction

    task automatic run_batch(input logic [BW-1:0] w0, w1, w2, w3, input bit bp,
                             input string tag, output int exec_cyc);
        logic [BW-1:0] w[4];
        int base, rb, wf, n;
        w = '{w0, w1, w2, w3};
        base = got.size(); rb = rden_cnt; wf = wren_full;
        for (int i = 0; i < 4; i++) q.push_back(w[i]);
        n = 0;
        while (in_valid !== 8'hFF && n < 300) begin @(negedge bus_clk); n++; end
        chk({tag, " recv_bound"}, 128'(n < 300), 128'(1));
        chk({tag, " in_data"}, 128'(in_data), {w3, w2, w1, w0});
        exec_cyc = 0;
        while (!send_wren && exec_cyc < 300) begin @(negedge bus_clk); exec_cyc++; end
        if (bp) begin
            n = 0;
            while (got.size() == base && n < 50) begin @(negedge bus_clk); n++; end
            send_full = 1'b1;
            repeat (5) @(negedge bus_clk);
            send_full = 1'b0;
        end
        n = 0;
        while (got.size() < base + 4 && n < 300) begin @(negedge bus_clk); n++; end
        chk({tag, " send_bound"}, 128'(n < 300), 128'(1));
        chk({tag, " busy_idle"}, 128'(busy), 128'(0));
        exp_batches++;
        chk({tag, " batch_count"}, 128'(batch_count), 128'(exp_batches));
        chk({tag, " rden_pulses"}, 128'(rden_cnt - rb), 128'(4));
        chk({tag, " wren_while_full"}, 128'(wren_full - wf), 128'(0));
        for (int i = 0; i < 4; i++)
            chk({tag, " send_word"}, 128'((got.size() > base + i) ? got[base + i] : 32'hx),
                128'(echo_word(w[i])));
    endtask

    initial begin
        int ec, ib, n;
        bus_rst_n = 1'b0; enable = 1'b0; send_full = 1'b0;
        repeat (3) @(negedge bus_clk);
        chk("rst busy", 128'(busy), 128'(0));
        chk("rst in_valid", 128'(in_valid), 128'(0));
        chk("rst in_data", 128'(in_data), 128'(0));
        chk("rst batch_count", 128'(batch_count), 128'(0));
        chk("rst rden_wren", 128'({recv_rden, send_wren}), 128'(0));
        chk("rst timeout_flag", 128'(timeout_flag), 128'(0));
        bus_rst_n = 1'b1;
        @(negedge bus_clk);
        enable = 1'b1;
        @(negedge bus_clk);

        ib = ivq.size();
        run_batch(32'h00020001, 32'h00040003, 32'h00060005, 32'h00080007, 0, "nominal", ec);
        chk("nominal iv0", 128'(ivq[ib]), 128'(8'h03));
        chk("nominal iv1", 128'(ivq[ib+1]), 128'(8'h0F));
        chk("nominal iv2", 128'(ivq[ib+2]), 128'(8'h3F));
        chk("nominal iv3", 128'(ivq[ib+3]), 128'(8'hFF));
        chk("nominal exec_cycles", 128'(ec), 128'(4));

        starve = 1;
        run_batch($urandom(), $urandom(), $urandom(), $urandom(), 0, "starved", ec);
        starve = 0;

        run_batch($urandom(), $urandom(), $urandom(), $urandom(), 1, "backpressure", ec);

        // Completion and timeout in the same cycle: completion must win.
        kdelay = TO - 1;
        run_batch($urandom(), $urandom(), $urandom(), $urandom(), 0, "tie", ec);
        chk("tie exec_cycles", 128'(ec), 128'(TO));
        chk("tie timeout_flag", 128'(timeout_flag), 128'(0));

        tmo_mode = 1;
        run_batch($urandom(), $urandom(), $urandom(), $urandom(), 0, "timeout", ec);
        chk("timeout exec_cycles", 128'(ec), 128'(TO));
        chk("timeout flag_set", 128'(timeout_flag), 128'(1));
        tmo_mode = 0; kdelay = 3;
        run_batch($urandom(), $urandom(), $urandom(), $urandom(), 0, "sticky", ec);
        chk("sticky flag_held", 128'(timeout_flag), 128'(1));
        enable = 1'b0;
        @(negedge bus_clk);
        chk("disable flag_clear", 128'(timeout_flag), 128'(0));
        chk("disable busy", 128'(busy), 128'(0));

        enable = 1'b1;
        q.push_back($urandom()); q.push_back($urandom());
        n = 0;
        while (in_valid !== 8'h0F && n < 100) begin @(negedge bus_clk); n++; end
        chk("abort two_words", 128'(in_valid), 128'(8'h0F));
        enable = 1'b0;
        @(negedge bus_clk);
        chk("abort busy", 128'(busy), 128'(0));
        chk("abort in_valid", 128'(in_valid), 128'(0));
        enable = 1'b1;
        @(negedge bus_clk);
        ib = ivq.size();
        run_batch($urandom(), $urandom(), $urandom(), $urandom(), 0, "reenable", ec);
        chk("reenable first_iv", 128'(ivq[ib]), 128'(8'h03));

        // Stall in SEND, then reset between clock edges.
        send_full = 1'b1;
        for (int i = 0; i < 4; i++) q.push_back($urandom());
        n = 0;
        while (in_valid !== 8'hFF && n < 100) begin @(negedge bus_clk); n++; end
        repeat (6) @(negedge bus_clk);
        #2 send_full = 1'b0;
        #1 chk("presreset send_wren", 128'(send_wren), 128'(1));
        bus_rst_n = 1'b0;
        #1;
        chk("async_rst send_wren", 128'(send_wren), 128'(0));
        chk("async_rst busy", 128'(busy), 128'(0));
        chk("async_rst batch_count", 128'(batch_count), 128'(0));
        chk("async_rst in_valid", 128'(in_valid), 128'(0));
        @(negedge bus_clk);
        bus_rst_n = 1'b1;
        @(negedge bus_clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
